// File: rtl/pixel_mem_pkg.sv
// Shared types and defaults for the pixel memory arbiter slice.
package pixel_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEF_IMG_W      = 256;
    localparam int DEF_IMG_H      = 256;
    localparam int DEF_ADDR_W     = 16;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_FIFO_DEPTH = 4;

    // Number of pixels in one frame.
    function automatic int frame_len(input int w, input int h);
        return w * h;
    endfunction

endpackage

// File: rtl/pixel_mem_arbiter_fifo.sv
// Small show-ahead FIFO holding prefetched pixels for the VGA path.
// The head is visible on dout_o without a pop; dout_o reads 0 when empty.
module pixel_fifo
    import pixel_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_FIFO_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              empty_o,
    output logic              full_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_q, wr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign count_o = cnt_q;
    assign dout_o  = empty_o ? '0 : mem_q[rd_q];

    // A full FIFO may still accept a push when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Storage, pointers and occupancy; flush empties the FIFO in one edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) rd_q <= rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/pixel_mem_arbiter.sv
// Shares one single-port image RAM between raster-order display prefetch and
// decryptor writes. Fetch always wins; writes fill every cycle fetch leaves idle.
module pixel_mem_arbiter
    import pixel_mem_pkg::*;
#(
    parameter int IMG_W      = DEF_IMG_W,
    parameter int IMG_H      = DEF_IMG_H,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk_25Mhz,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              pix_req,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    output logic              underflow,
    output logic              frame_done,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int                N         = frame_len(IMG_W, IMG_H);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
    localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;

    state_t            state_q;
    logic [ADDR_W-1:0] fetch_addr_q, pop_cnt_q, mem_addr_q, mem_addr_d;
    logic              inflight_q, underflow_q, frame_done_q;
    logic [CNT_W-1:0]  fifo_cnt, credit;
    logic              fifo_empty, fifo_full;
    logic              fetch_issue, push, pop;
    logic [DATA_W-1:0] head;

    // Credit counts the in-flight read so the FIFO can never be overrun.
    assign credit      = fifo_cnt + CNT_W'(inflight_q);
    assign fetch_issue = (state_q == FETCH) && !fifo_full && (credit < CNT_W'(FIFO_DEPTH));

    // A restart discards both the in-flight read and any pop in that cycle.
    assign push   = inflight_q && !frame_start;
    assign pop    = pix_req && !fifo_empty && !frame_start;
    assign wr_gnt = wr_req && !fetch_issue && !rst;

    pixel_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_25Mhz),
        .rst_i   (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (frame_start),
        .din_i   (mem_rdata),
        .dout_o  (head),
        .count_o (fifo_cnt),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign pix_data   = head;
    assign pix_valid  = !fifo_empty;
    assign underflow  = underflow_q;
    assign frame_done = frame_done_q;
    assign mem_addr   = mem_addr_d;

    // RAM port mux: fetch, else granted write, else hold the last address.
    always_comb begin
        mem_addr_d = mem_addr_q;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        if (rst) begin
            mem_addr_d = '0;
        end else if (fetch_issue) begin
            mem_addr_d = fetch_addr_q;
        end else if (wr_gnt) begin
            mem_addr_d = wr_addr;
            mem_we     = 1'b1;
            mem_wdata  = wr_data;
        end
    end

    // Remembers the address last driven so an idle RAM port stays put.
    always_ff @(posedge clk_25Mhz or posedge rst) begin
        if (rst) mem_addr_q <= '0;
        else     mem_addr_q <= mem_addr_d;
    end

    // Frame FSM with fetch counter, in-flight flag and the status outputs.
    always_ff @(posedge clk_25Mhz or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            fetch_addr_q <= '0;
            pop_cnt_q    <= '0;
            inflight_q   <= 1'b0;
            underflow_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= pop && (pop_cnt_q == LAST_ADDR);
            if (pop) pop_cnt_q <= pop_cnt_q + 1'b1;
            inflight_q <= fetch_issue;
            // The counter parks on the last address rather than wrapping.
            if (fetch_issue && (fetch_addr_q != LAST_ADDR))
                fetch_addr_q <= fetch_addr_q + 1'b1;
            if (pix_req && fifo_empty) underflow_q <= 1'b1;
            case (state_q)
                IDLE:    state_q <= IDLE;
                FETCH:   if (fetch_issue && (fetch_addr_q == LAST_ADDR)) state_q <= DRAIN;
                DRAIN:   if (fifo_empty && !inflight_q) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            // A new frame overrides everything above, from any state.
            if (frame_start) begin
                state_q      <= FETCH;
                fetch_addr_q <= '0;
                pop_cnt_q    <= '0;
                inflight_q   <= 1'b0;
                underflow_q  <= 1'b0;
                frame_done_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pixel_mem_arbiter.sv
// Bench for pixel_mem_arbiter: directed scenarios plus random traffic, all
// checked every cycle against a queue-based model of the prefetch rules.
module tb_pixel_mem_arbiter;

    localparam int N     = 8;
    localparam int DEPTH = 4;

    logic       clk_25Mhz = 1'b0;
    logic       rst, frame_start, pix_req, wr_req, load_ram;
    logic [7:0] wr_addr, wr_data;
    logic [7:0] pix_data, mem_addr, mem_wdata, mem_rdata;
    logic       pix_valid, underflow, frame_done, wr_gnt, mem_we;
    logic [7:0] ram [0:255];

    pixel_mem_arbiter #(
        .IMG_W(4), .IMG_H(2), .ADDR_W(8), .DATA_W(8), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_25Mhz   (clk_25Mhz),
        .rst         (rst),
        .frame_start (frame_start),
        .pix_req     (pix_req),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .underflow   (underflow),
        .frame_done  (frame_done),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_gnt      (wr_gnt),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #20 clk_25Mhz = ~clk_25Mhz;

    // Single-port RAM, read-first, one cycle read latency.
    always @(posedge clk_25Mhz) begin
        if (load_ram) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'(i + 16);
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    // Reference model state: image contents and the queue of prefetched pixels.
    int img [256];
    int q [$];
    int infl, infl_val, nxt, active, uf, done, pops, last_addr;
    int nchk, nerr;
    int popped [$];
    int ndone, ngnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        infl = 0; infl_val = 0; nxt = 0; active = 0;
        uf = 0; done = 0; pops = 0; last_addr = 0;
    endtask

    // One clock cycle: drive inputs, check against model, advance model at the edge.
    task automatic cyc(input bit fs, input bit rq, input bit wq, input int wa, input int wd);
        bit issue, gnt, pop;
        int ea;
        frame_start = fs; pix_req = rq; wr_req = wq;
        wr_addr = wa[7:0]; wr_data = wd[7:0];
        #1;
        issue = (active != 0) && (nxt < N) && ((q.size() + infl) < DEPTH);
        gnt   = wq && !issue;
        pop   = !fs && rq && (q.size() > 0);
        ea    = issue ? nxt : (gnt ? wa : last_addr);
        chk("pix_valid", pix_valid, q.size() > 0);
        chk("pix_data", pix_data, (q.size() > 0) ? q[0] : 0);
        chk("underflow", underflow, uf);
        chk("frame_done", frame_done, done);
        chk("wr_gnt", wr_gnt, gnt);
        chk("mem_we", mem_we, gnt);
        chk("mem_addr", mem_addr, ea);
        if (gnt) chk("mem_wdata", mem_wdata, wd & 255);
        if (rq && pix_valid && !fs) popped.push_back(int'(pix_data));
        if (frame_done) ndone++;
        if (wr_gnt) ngnt++;
        @(posedge clk_25Mhz);
        last_addr = ea;
        if (gnt) img[wa & 255] = wd & 255;
        if (fs) begin
            q.delete();
            infl = 0; nxt = 0; active = 1; pops = 0; uf = 0; done = 0;
        end else begin
            done = (pop && pops == N - 1) ? 1 : 0;
            if (rq && q.size() == 0) uf = 1;
            if (pop) begin
                void'(q.pop_front());
                pops++;
            end
            if (infl != 0) q.push_back(infl_val);
            infl = issue ? 1 : 0;
            if (issue) begin
                infl_val = img[nxt];
                nxt++;
            end
        end
        @(negedge clk_25Mhz);
    endtask

    initial begin
        int granted, g0;
        nchk = 0; nerr = 0; ndone = 0; ngnt = 0;
        rst = 1'b1; load_ram = 1'b1;
        frame_start = 0; pix_req = 0; wr_req = 0; wr_addr = 0; wr_data = 0;
        for (int i = 0; i < 256; i++) img[i] = (i + 16) % 256;
        model_reset();
        @(negedge clk_25Mhz);
        @(negedge clk_25Mhz);
        load_ram = 1'b0;
        // Reset state, with a write request pending that must not be granted.
        wr_req = 1; wr_addr = 8'h33; wr_data = 8'h44; pix_req = 1;
        #1;
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_pix_data", pix_data, 0);
        chk("rst_underflow", underflow, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_wr_gnt", wr_gnt, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        wr_req = 0; pix_req = 0;
        @(negedge clk_25Mhz);
        rst = 1'b0;

        // Full frame with continuous popping once pixels arrive.
        popped.delete(); ndone = 0;
        cyc(1, 0, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 0);
        repeat (8) cyc(0, 1, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0);
        chk("f1_pops", popped.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < popped.size()) chk("f1_pixel", popped[i], i + 16);
        chk("f1_done_cnt", ndone, 1);
        chk("f1_no_underflow", underflow, 0);

        // No pops: four reads then a stall; one pop releases exactly one read.
        cyc(1, 0, 0, 0, 0);
        repeat (8) cyc(0, 0, 0, 0, 0);
        chk("stall_addr", mem_addr, 3);
        chk("stall_head", pix_data, 16);
        cyc(0, 1, 0, 0, 0);
        #1;
        chk("credit_release", mem_addr, 4);
        repeat (10) cyc(0, 1, 0, 0, 0);

        // Writes lose to every fetch issue during a frame.
        cyc(1, 0, 0, 0, 0);
        ngnt = 0;
        repeat (14) cyc(0, 1, 1, 200, $urandom_range(0, 255));
        chk("gnt_in_fetch", ngnt, 6);
        ngnt = 0;
        repeat (5) cyc(0, 0, 1, 201, $urandom_range(0, 255));
        chk("gnt_in_idle", ngnt, 5);

        // A write to a not-yet-fetched pixel shows up in the same frame.
        cyc(1, 0, 0, 0, 0);
        granted = 0;
        for (int k = 0; k < 20 && granted == 0; k++) begin
            g0 = ngnt;
            cyc(0, 0, 1, 5, 'hAA);
            if (ngnt != g0) granted = 1;
        end
        chk("wr5_granted", granted, 1);
        popped.delete();
        repeat (12) cyc(0, 1, 0, 0, 0);
        chk("wr5_pops", popped.size(), 8);
        if (popped.size() > 5) chk("wr5_pixel", popped[5], 'hAA);

        // Early pop sets sticky underflow; the next frame clears it.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("uf_set", underflow, 1);
        cyc(0, 0, 0, 0, 0);
        chk("uf_sticky", underflow, 1);
        cyc(1, 0, 0, 0, 0);
        chk("uf_clear", underflow, 0);

        // Restart after three pops flushes; first new pixel is RAM[0].
        cyc(0, 0, 0, 0, 0);
        repeat (3) cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        popped.delete();
        repeat (2) cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk("restart_cnt", popped.size(), 1);
        if (popped.size() > 0) chk("restart_pixel", popped[0], 16);
        repeat (10) cyc(0, 1, 0, 0, 0);

        // Asynchronous reset in the middle of fetching.
        cyc(1, 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0);
        wr_req = 1; wr_addr = 8'h12; wr_data = 8'h34; pix_req = 1;
        rst = 1'b1;
        #1;
        chk("mid_rst_pix_valid", pix_valid, 0);
        chk("mid_rst_pix_data", pix_data, 0);
        chk("mid_rst_wr_gnt", wr_gnt, 0);
        chk("mid_rst_mem_we", mem_we, 0);
        chk("mid_rst_mem_addr", mem_addr, 0);
        chk("mid_rst_mem_wdata", mem_wdata, 0);
        model_reset();
        @(negedge clk_25Mhz);
        rst = 1'b0;
        wr_req = 0; pix_req = 0;

        // Random traffic checked cycle by cycle against the model.
        cyc(1, 0, 0, 0, 0);
        for (int k = 0; k < 400; k++)
            cyc($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 2) == 0, int'($urandom_range(0, 15)),
                int'($urandom_range(0, 255)));

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
